// File: rtl/cto2_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// cto2_sweep_ctrl
//
// This block runs an exhaustive sweep of one CTO2 combinational cell, where
// s = a'b'c + a'bc + ab'c'. A start request makes it drive all eight {a,b,c}
// vectors in ascending order. It holds each vector for SETTLE_CYCLES+1 cycles
// and captures s_i into a shadow truth table at the last edge of that window.
// When the sweep completes, the shadow table is published and compared with
// EXPECTED to produce pass, a mismatch count and the lowest failing vector.
//
// Parameters
//   SETTLE_CYCLES  extra hold cycles per vector before sampling (0..15)
//   EXPECTED       golden truth table, bit i = s for vector i = {a,b,c}
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     sweep request, honoured only in IDLE
//   abort     cancels a running sweep (SETTLE only)
//   loop      (CTO2_SWEEP_LOOP_EN only) restart the sweep after each DONE
//   a_o/b_o/c_o  registered vector driven to the cell under test
//   s_i       output of the cell under test
//   busy      high while a sweep is in SETTLE
//   done      one-cycle pulse when a sweep completes
//   table_o   truth table captured by the last completed sweep
//   pass      table_o == EXPECTED
//   err_cnt   number of mismatching table bits (0..8)
//   fail_idx  lowest mismatching vector index, 0 when passing
//
// Optional feature macro: CTO2_SWEEP_LOOP_EN
//   When it is defined, the block gets the extra input 'loop'. If loop is high
//   in the DONE cycle, a new sweep starts instead of returning to IDLE.
// ---------------------------------------------------------------------------
module cto2_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h1A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
`ifdef CTO2_SWEEP_LOOP_EN
  input  logic       loop,
`endif
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  input  logic       s_i,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_o,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_idx
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic [2:0]  vec_q,     vec_d;
  logic [3:0]  cnt_q,     cnt_d;
  logic [7:0]  shadow_q,  shadow_d;
  logic [7:0]  table_q,   table_d;
  logic        pass_q,    pass_d;
  logic [3:0]  errCnt_q,  errCnt_d;
  logic [2:0]  failIdx_q, failIdx_d;

  // This is the shadow table with the current sample merged in. It is the
  // value the table will hold after this edge if a sample is taken now. The
  // final vector's sample therefore reaches the published results at the
  // same edge that enters DONE.
  logic [7:0]  shadowSampled;
  logic [7:0]  mismatch;
  logic [3:0]  mismatchCount;
  logic [2:0]  mismatchIdx;

  always_comb begin
    shadowSampled        = shadow_q;
    shadowSampled[vec_q] = s_i;
  end

  // Compare against the golden table. The index scan runs from the top bit
  // downward, so the last assignment made is the lowest mismatching vector.
  always_comb begin
    mismatch      = shadowSampled ^ EXPECTED;
    mismatchCount = 4'd0;
    mismatchIdx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mismatch[i]) begin
        mismatchCount = mismatchCount + 4'd1;
        mismatchIdx   = 3'(i);
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    table_d   = table_q;
    pass_d    = pass_q;
    errCnt_d  = errCnt_q;
    failIdx_d = failIdx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          vec_d    = 3'd0;
          cnt_d    = SETTLE_LOAD;
          shadow_d = 8'h00;
        end
      end

      SETTLE: begin
        // Abort is checked before sampling. The partial shadow table is
        // simply abandoned, and the next start clears it.
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          shadow_d = shadowSampled;
          if (vec_q == 3'd7) begin
            state_d   = DONE;
            table_d   = shadowSampled;
            pass_d    = (shadowSampled == EXPECTED);
            errCnt_d  = mismatchCount;
            failIdx_d = mismatchIdx;
          end else begin
            vec_d = vec_q + 3'd1;
            cnt_d = SETTLE_LOAD;
          end
        end
      end

      DONE: begin
`ifdef CTO2_SWEEP_LOOP_EN
        if (loop) begin
          state_d  = SETTLE;
          vec_d    = 3'd0;
          cnt_d    = SETTLE_LOAD;
          shadow_d = 8'h00;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= 3'd0;
      cnt_q     <= 4'd0;
      shadow_q  <= 8'h00;
      table_q   <= 8'h00;
      pass_q    <= 1'b0;
      errCnt_q  <= 4'd0;
      failIdx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      table_q   <= table_d;
      pass_q    <= pass_d;
      errCnt_q  <= errCnt_d;
      failIdx_q <= failIdx_d;
    end
  end

  assign a_o      = vec_q[2];
  assign b_o      = vec_q[1];
  assign c_o      = vec_q[0];
  assign busy     = (state_q == SETTLE);
  assign done     = (state_q == DONE);
  assign table_o  = table_q;
  assign pass     = pass_q;
  assign err_cnt  = errCnt_q;
  assign fail_idx = failIdx_q;

endmodule

// File: tb/tb_cto2_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cto2_sweep_ctrl
//
// Self-checking bench for cto2_sweep_ctrl. A behavioural CTO2 cell sits on
// s_i. It can be correct, stuck at 0, or inverted. Sweep results come from a
// table of records. Abort, start-while-busy, mid-sweep reset and (when
// CTO2_SWEEP_LOOP_EN is defined) loop mode are covered by hand sequences.
// ---------------------------------------------------------------------------
module tb_cto2_sweep_ctrl;

`ifdef CTO2_SWEEP_LOOP_EN
  localparam int SC = 0;
`else
  localparam int SC = 2;
`endif
  localparam int HOLD = SC + 1;
  localparam int LAST = 8 * HOLD;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
`ifdef CTO2_SWEEP_LOOP_EN
  logic       loop;
`endif
  logic       a_o, b_o, c_o;
  logic       s_i;
  logic       busy, done, pass;
  logic [7:0] table_o;
  logic [3:0] err_cnt;
  logic [2:0] fail_idx;

  int         sMode;
  logic       refS;
  int         checks;
  int         errors;

  typedef struct {
    int         mode;
    logic [7:0] expTable;
    logic       expPass;
    logic [3:0] expErr;
    logic [2:0] expIdx;
  } sweep_t;

  sweep_t vectors [4];

  cto2_sweep_ctrl #(
    .SETTLE_CYCLES(SC),
    .EXPECTED     (8'h1A)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
`ifdef CTO2_SWEEP_LOOP_EN
    .loop    (loop),
`endif
    .a_o     (a_o),
    .b_o     (b_o),
    .c_o     (c_o),
    .s_i     (s_i),
    .busy    (busy),
    .done    (done),
    .table_o (table_o),
    .pass    (pass),
    .err_cnt (err_cnt),
    .fail_idx(fail_idx)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CTO2 cell; sMode selects correct (0), stuck-at-0 (1) or inverted (2)
  always_comb begin
    refS = (~a_o & ~b_o & c_o) | (~a_o & b_o & c_o) | (a_o & ~b_o & ~c_o);
    case (sMode)
      1:       s_i = 1'b0;
      2:       s_i = ~refS;
      default: s_i = refS;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResults(input logic [7:0] t, input logic p,
                              input logic [3:0] e, input logic [2:0] i);
    checkOutput("table_o", table_o, t);
    checkOutput("pass", pass, p);
    checkOutput("err_cnt", err_cnt, e);
    checkOutput("fail_idx", fail_idx, i);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_abc"}, {a_o, b_o, c_o}, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkResults(8'h00, 1'b0, 4'd0, 3'd0);
  endtask

  // Runs one full sweep. On return the bench is one step past the edge that
  // entered DONE (edge E LAST).
  task automatic applyStimulus(input int m);
    sMode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < LAST; k++) begin
      checkOutput("busy", busy, 1);
      checkOutput("vec", {a_o, b_o, c_o}, k / HOLD);
      checkOutput("doneEarly", done, 0);
      @(posedge clk); #1;
    end
    checkOutput("doneAtLast", done, 1);
    checkOutput("busyAtLast", busy, 0);
    checkOutput("vecHeld", {a_o, b_o, c_o}, 7);
  endtask

  initial begin
    int waitCnt;
    logic sawDone;

    checks = 0;
    errors = 0;
    sMode  = 0;
    start  = 1'b0;
    abort  = 1'b0;
`ifdef CTO2_SWEEP_LOOP_EN
    loop   = 1'b0;
`endif
    rst_n  = 1'b0;

    vectors[0] = '{mode: 0, expTable: 8'h1A, expPass: 1'b1, expErr: 4'd0, expIdx: 3'd0};
    vectors[1] = '{mode: 1, expTable: 8'h00, expPass: 1'b0, expErr: 4'd3, expIdx: 3'd1};
    vectors[2] = '{mode: 2, expTable: 8'hE5, expPass: 1'b0, expErr: 4'd8, expIdx: 3'd0};
    vectors[3] = '{mode: 0, expTable: 8'h1A, expPass: 1'b1, expErr: 4'd0, expIdx: 3'd0};

    #12;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven sweeps, back to back (start in the cycle after DONE)
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vectors[v].mode);
      checkResults(vectors[v].expTable, vectors[v].expPass,
                   vectors[v].expErr, vectors[v].expIdx);
      @(posedge clk); #1;
      checkOutput("doneDrop", done, 0);
    end

    // Start held high during busy must not change the sweep length
    sMode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    waitCnt = 0;
    while (!done && waitCnt < 4 * LAST) begin
      if (waitCnt == 4) start = 1'b0;
      @(posedge clk); #1;
      waitCnt++;
    end
    start = 1'b0;
    checkOutput("sweepLenWithStart", waitCnt, LAST);
    checkResults(8'h00, 1'b0, 4'd3, 3'd1);
    @(posedge clk); #1;

    // Restore a passing result, then abort a sweep part-way through
    applyStimulus(0);
    checkResults(8'h1A, 1'b1, 4'd0, 3'd0);
    @(posedge clk); #1;
    sMode = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < (LAST * 5) / 12; k++) begin
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    sawDone = 1'b0;
    for (int k = 0; k < LAST + 4; k++) begin
      if (done || busy) sawDone = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("noActivityAfterAbort", sawDone, 0);
    checkResults(8'h1A, 1'b1, 4'd0, 3'd0);

    // Asynchronous reset in the middle of a sweep
    sMode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < LAST / 2; k++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idleAfterReset", busy, 0);
    applyStimulus(0);
    checkResults(8'h1A, 1'b1, 4'd0, 3'd0);
    @(posedge clk); #1;

`ifdef CTO2_SWEEP_LOOP_EN
    // Loop mode: done every LAST+1 cycles until loop drops
    loop  = 1'b1;
    sMode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= LAST + 4 * (LAST + 1) + 2; k++) begin
      @(posedge clk); #1;
      if (k == LAST + 2 * (LAST + 1) + 1) loop = 1'b0;
      checkOutput("loopDone", done,
                  ((k >= LAST) && ((k - LAST) % (LAST + 1) == 0) &&
                   (k <= LAST + 3 * (LAST + 1))) ? 1 : 0);
    end
    checkOutput("loopStopped", busy, 0);
    checkResults(8'h1A, 1'b1, 4'd0, 3'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
